shifter_stream_scheduler: RTL and testbench
===========================================

Name: shifter_stream_scheduler

Overview:
- Shares one BarrelShifter instance between two AXI-Stream requesters, with packet-granular round-robin arbitration.
- Converts valid/ready handshakes into the shifter's single global `enable` stall signal.
- Tracks requester ID through the shifter pipeline with a tag shift register.
- Buffers shifter results in a small output FIFO, so downstream backpressure freezes the pipeline losslessly.
- Sits between the compression front-end lanes and the packing stage.

Parameters:
- SHIFT_LATENCY, 7: shifter enable-cycles from `sh_valid_in` to `sh_valid_out`; depth of the tag pipeline.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- s0_data  in  512  requester 0 data
- s0_keep  in  64  requester 0 byte keep
- s0_last  in  1  requester 0 end of packet
- s0_flag  in  1  requester 0 last_transfer_flag
- s0_valid  in  1  requester 0 valid
- s0_ready  out  1  requester 0 ready
- s1_data, s1_keep, s1_last, s1_flag, s1_valid, s1_ready: same as s0_*, for requester 1
- sh_enable  out  1  shifter enable
- sh_data_in  out  512  to shifter
- sh_keep_in  out  64  to shifter
- sh_valid_in  out  1  to shifter
- sh_last_in  out  1  to shifter
- sh_flag_in  out  1  to shifter
- sh_data_out  in  512  from shifter
- sh_keep_out  in  64  from shifter
- sh_valid_out  in  1  from shifter
- sh_last_out  in  1  from shifter
- sh_flag_out  in  1  from shifter
- sh_offset_out  in  7  from shifter
- m_data  out  512  output data
- m_keep  out  64  output keep
- m_last  out  1  output end of packet
- m_flag  out  1  output last_transfer_flag
- m_offset  out  7  output offset
- m_tid  out  1  originating requester
- m_valid  out  1  output valid
- m_ready  in  1  output ready

Behaviour:
- Reset (async, any cycle, including mid-packet):
  - FSM to IDLE; grant and rr_ptr to 0.
  - Tag pipeline cleared; FIFO emptied (count=0).
  - Outputs: m_valid=0, s0_ready=s1_ready=0, sh_valid_in=0, sh_enable=1 (count=0).
  - Beats in flight in the shifter are discarded; the shifter's own reset is driven by top level from the same source.
- sh_enable:
  - sh_enable = (fifo_count < FIFO_DEPTH); registered count only.
  - No combinational path from m_ready.
- FSM IDLE:
  - Register the grant from the valids.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant rr_ptr. Go to BUSY the next cycle.
  - No requester is ready in IDLE; one bubble per packet.
- FSM BUSY:
  - Granted requester ready = sh_enable; the other requester's ready = 0.
  - Beat accepted = valid & ready.
  - Accepted beat with last=1: go to IDLE; rr_ptr = ~grant.
- Shifter drive:
  - sh_data_in, sh_keep_in, sh_last_in, sh_flag_in = granted requester fields (mux, combinational).
  - sh_valid_in = accepted beat.
  - In IDLE, or with no valid, sh_valid_in=0 while enabled; bubbles flush the pipeline.
- Tag pipeline:
  - SHIFT_LATENCY entries, shift only when sh_enable=1.
  - Entry 0 ← grant.
  - The last entry is the tid aligned with sh_valid_out.
- FIFO:
  - push = sh_enable & sh_valid_out; stores data, keep, last, flag, offset, tid.
  - pop = m_valid & m_ready.
  - m_valid = count≠0; outputs show the head entry.
  - Simultaneous push and pop: count unchanged.
  - Push is never attempted when full, because sh_enable=0 freezes the shifter.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: beats are never dropped, duplicated or reordered; per-requester packets are contiguous on m_*.
- Throughput: 1 beat/cycle within a packet when m_ready=1.

Decomposition:
- Package shifter_sched_pkg:
  - constants DATA_W=512, KEEP_W=64, OFFSET_W=7, NUM_REQ=2.
  - typedef beat_t: data, keep, last, flag, offset, tid.
  - enum state_t {IDLE, BUSY}.
- Sub-module shifter_out_fifo: parameterised beat_t FIFO with count output and async active-high reset.

Test Plan:
- Single packet: s0 sends 3 beats, keep=all-ones, last on beat 3, m_ready=1.
  → Beat 1 appears on m_* exactly SHIFT_LATENCY+1 cycles after its s0 handshake (+1 for FIFO register), tid=0.
  → Data identical to what the shifter emits; m_last on beat 3 only.
- Fairness: s0 and s1 continuously valid with 2-beat packets.
  → m_tid sequence 0,0,1,1,0,0,1,1; each packet contiguous.
- Backpressure: m_ready=0 for 20 cycles during a 10-beat s1 packet.
  → FIFO fills to 4; sh_enable=0; s1_ready=0.
  → After m_ready=1, all 10 beats delivered in order, none lost.
- Simultaneous push/pop: m_ready=1 with FIFO holding 2 entries and a new sh_valid_out.
  → count stays 2; sh_enable remains 1.
- Reset mid-packet: assert areset for 1 cycle after beat 2 of 5.
  → Immediately m_valid=0, s*_ready=0, count=0.
  → After release, a new s1 packet is granted from IDLE (rr_ptr=0, only s1 valid) with tid=1.

Source files
------------

// File: rtl/shifter_sched_pkg.sv
// Shared types and widths for the shifter stream scheduler.
package shifter_sched_pkg;

    localparam int DATA_W   = 512;
    localparam int KEEP_W   = 64;
    localparam int OFFSET_W = 7;
    localparam int NUM_REQ  = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] tid_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [KEEP_W-1:0]   keep;
        logic                last;
        logic                flag;
        logic [OFFSET_W-1:0] offset;
        tid_t                tid;
    } beat_t;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/shifter_out_fifo.sv
// Small beat FIFO behind the shifter; the count feeds the global stall.
module shifter_out_fifo
    import shifter_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  beat_t                  din,
    input  logic                   pop,
    output beat_t                  dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/shifter_stream_scheduler.sv
// Packet round-robin sharing of one barrel shifter between two streams,
// with a tag pipeline for requester ID and a stall-driven output FIFO.
module shifter_stream_scheduler
    import shifter_sched_pkg::*;
#(
    parameter int SHIFT_LATENCY = 7,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [DATA_W-1:0]   s0_data,
    input  logic [KEEP_W-1:0]   s0_keep,
    input  logic                s0_last,
    input  logic                s0_flag,
    input  logic                s0_valid,
    output logic                s0_ready,
    input  logic [DATA_W-1:0]   s1_data,
    input  logic [KEEP_W-1:0]   s1_keep,
    input  logic                s1_last,
    input  logic                s1_flag,
    input  logic                s1_valid,
    output logic                s1_ready,
    output logic                sh_enable,
    output logic [DATA_W-1:0]   sh_data_in,
    output logic [KEEP_W-1:0]   sh_keep_in,
    output logic                sh_valid_in,
    output logic                sh_last_in,
    output logic                sh_flag_in,
    input  logic [DATA_W-1:0]   sh_data_out,
    input  logic [KEEP_W-1:0]   sh_keep_out,
    input  logic                sh_valid_out,
    input  logic                sh_last_out,
    input  logic                sh_flag_out,
    input  logic [OFFSET_W-1:0] sh_offset_out,
    output logic [DATA_W-1:0]   m_data,
    output logic [KEEP_W-1:0]   m_keep,
    output logic                m_last,
    output logic                m_flag,
    output logic [OFFSET_W-1:0] m_offset,
    output tid_t                m_tid,
    output logic                m_valid,
    input  logic                m_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                   state;
    tid_t                     grant;
    tid_t                     rr_ptr;
    tid_t [SHIFT_LATENCY-1:0] tag_pipe;
    logic [CNT_W-1:0]         fifo_count;
    logic                     sel_valid;
    logic                     accept;
    logic                     push;
    logic                     pop;
    beat_t                    push_beat;
    beat_t                    head;

    // Stall is a pure function of the registered count: no path from m_ready.
    assign sh_enable = (fifo_count < CNT_W'(FIFO_DEPTH));

    assign sel_valid  = grant[0] ? s1_valid : s0_valid;
    assign sh_data_in = grant[0] ? s1_data  : s0_data;
    assign sh_keep_in = grant[0] ? s1_keep  : s0_keep;
    assign sh_last_in = grant[0] ? s1_last  : s0_last;
    assign sh_flag_in = grant[0] ? s1_flag  : s0_flag;

    assign s0_ready    = (state == BUSY) && !grant[0] && sh_enable;
    assign s1_ready    = (state == BUSY) &&  grant[0] && sh_enable;
    assign accept      = (state == BUSY) && sel_valid && sh_enable;
    assign sh_valid_in = accept;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (s0_valid || s1_valid) begin
                    grant <= (s0_valid && s1_valid) ? rr_ptr : tid_t'(s1_valid);
                    state <= BUSY;
                end
                BUSY: if (accept && sh_last_in) begin
                    state  <= IDLE;
                    rr_ptr <= ~grant;
                end
            endcase
        end
    end

    // Advances in lockstep with the shifter so the tail lines up with sh_valid_out.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)         tag_pipe <= '0;
        else if (sh_enable) tag_pipe <= {tag_pipe[SHIFT_LATENCY-2:0], grant};
    end

    assign push = sh_enable && sh_valid_out;
    assign pop  = m_valid && m_ready;

    assign push_beat.data   = sh_data_out;
    assign push_beat.keep   = sh_keep_out;
    assign push_beat.last   = sh_last_out;
    assign push_beat.flag   = sh_flag_out;
    assign push_beat.offset = sh_offset_out;
    assign push_beat.tid    = tag_pipe[SHIFT_LATENCY-1];

    shifter_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    assign m_valid  = (fifo_count != '0);
    assign m_data   = head.data;
    assign m_keep   = head.keep;
    assign m_last   = head.last;
    assign m_flag   = head.flag;
    assign m_offset = head.offset;
    assign m_tid    = head.tid;

endmodule

// File: tb/tb_shifter_stream_scheduler.sv
// Directed bench: behavioural shifter pipeline, output monitor, hand-computed beats.
module tb_shifter_stream_scheduler;

    localparam int LAT = 7;

    logic         aclk = 1'b0;
    logic         areset;
    logic [511:0] s0_data, s1_data;
    logic [63:0]  s0_keep, s1_keep;
    logic         s0_last, s0_flag, s0_valid, s0_ready;
    logic         s1_last, s1_flag, s1_valid, s1_ready;
    logic         sh_enable, sh_valid_in, sh_last_in, sh_flag_in;
    logic [511:0] sh_data_in, sh_data_out;
    logic [63:0]  sh_keep_in, sh_keep_out;
    logic         sh_valid_out, sh_last_out, sh_flag_out;
    logic [6:0]   sh_offset_out;
    logic [511:0] m_data;
    logic [63:0]  m_keep;
    logic         m_last, m_flag, m_tid, m_valid, m_ready;
    logic [6:0]   m_offset;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    shifter_stream_scheduler #(.SHIFT_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_data(s0_data), .s0_keep(s0_keep), .s0_last(s0_last), .s0_flag(s0_flag),
        .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_keep(s1_keep), .s1_last(s1_last), .s1_flag(s1_flag),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .sh_enable(sh_enable), .sh_data_in(sh_data_in), .sh_keep_in(sh_keep_in),
        .sh_valid_in(sh_valid_in), .sh_last_in(sh_last_in), .sh_flag_in(sh_flag_in),
        .sh_data_out(sh_data_out), .sh_keep_out(sh_keep_out), .sh_valid_out(sh_valid_out),
        .sh_last_out(sh_last_out), .sh_flag_out(sh_flag_out), .sh_offset_out(sh_offset_out),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_flag(m_flag),
        .m_offset(m_offset), .m_tid(m_tid), .m_valid(m_valid), .m_ready(m_ready)
    );

    // Shifter stand-in: LAT enabled stages, data passes through, offset = data[6:0].
    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         f;
        logic         v;
    } sh_t;
    sh_t pst [LAT];

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < LAT; i++) pst[i] <= '0;
        end else if (sh_enable) begin
            pst[0] <= '{d:sh_data_in, k:sh_keep_in, l:sh_last_in, f:sh_flag_in, v:sh_valid_in};
            for (int i = 1; i < LAT; i++) pst[i] <= pst[i-1];
        end
    end

    assign sh_data_out   = pst[LAT-1].d;
    assign sh_keep_out   = pst[LAT-1].k;
    assign sh_last_out   = pst[LAT-1].l;
    assign sh_flag_out   = pst[LAT-1].f;
    assign sh_valid_out  = pst[LAT-1].v;
    assign sh_offset_out = pst[LAT-1].d[6:0];

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         f;
        logic [6:0]   o;
        logic         t;
        int           c;
    } rec_t;
    rec_t mon_q[$];

    always @(negedge aclk)
        if (!areset && m_valid && m_ready)
            mon_q.push_back('{d:m_data, k:m_keep, l:m_last, f:m_flag, o:m_offset, t:m_tid, c:cyc});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int req, input logic v, input logic [7:0] id, input int b, input logic last);
        logic [15:0] w;
        w = {id, 8'(b)};
        if (req == 0) begin
            s0_valid = v; s0_data = {32{w}}; s0_keep = '1; s0_last = last; s0_flag = (b == 0);
        end else begin
            s1_valid = v; s1_data = {32{w}}; s1_keep = '1; s1_last = last; s1_flag = (b == 0);
        end
    endtask

    // Sends beats 0..min(nbeats,stop_after)-1; returns #1 after the last accepted edge.
    task automatic send_pkt(input int req, input int nbeats, input logic [7:0] id, input int stop_after);
        for (int b = 0; b < nbeats && b < stop_after; b++) begin
            int waited = 0;
            drive(req, 1'b1, id, b, b == nbeats - 1);
            @(negedge aclk);
            while (!(req == 0 ? s0_ready : s1_ready) && waited <= 200) begin
                waited++;
                @(negedge aclk);
            end
            if (waited > 200) begin
                check($sformatf("handshake_timeout_req%0d", req), 64'(waited), 64'(0));
                drive(req, 1'b0, id, 0, 1'b0);
                return;
            end
            if (b == 0) hs_cyc = cyc;
            @(posedge aclk); #1;
        end
        drive(req, 1'b0, id, 0, 1'b0);
    endtask

    task automatic send_pkts(input int req, input int npkts, input int nbeats, input logic [7:0] id0);
        for (int p = 0; p < npkts; p++) send_pkt(req, nbeats, id0 + 8'(p), 99);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k = 0;
        while (mon_q.size() < n && k < 300) begin
            @(posedge aclk);
            k++;
        end
        repeat (12) @(posedge aclk);
        check({tag, "_beat_count"}, 64'(mon_q.size()), 64'(n));
    endtask

    task automatic wait_count(input int n);
        int k = 0;
        while (dut.fifo_count != 3'(n) && k < 100) begin
            @(negedge aclk);
            k++;
        end
    endtask

    task automatic check_beat(input int i, input logic [7:0] id, input int b, input logic last, input logic tid);
        logic [15:0] w;
        string t;
        w = {id, 8'(b)};
        t = $sformatf("beat%0d_%4h", i, w);
        check({t, "_present"}, 64'(i < mon_q.size()), 64'(1));
        if (i < mon_q.size()) begin
            check({t, "_data_lo"}, mon_q[i].d[63:0], {4{w}});
            check({t, "_data_hi"}, mon_q[i].d[511:448], {4{w}});
            check({t, "_keep"}, mon_q[i].k, 64'hFFFF_FFFF_FFFF_FFFF);
            check({t, "_last"}, 64'(mon_q[i].l), 64'(last));
            check({t, "_flag"}, 64'(mon_q[i].f), 64'(b == 0));
            check({t, "_offset"}, 64'(mon_q[i].o), 64'(w[6:0]));
            check({t, "_tid"}, 64'(mon_q[i].t), 64'(tid));
        end
    endtask

    initial begin
        areset = 1'b1;
        m_ready = 1'b1;
        drive(0, 1'b1, 8'h00, 0, 1'b0);
        drive(1, 1'b1, 8'h00, 0, 1'b0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_s0_ready", 64'(s0_ready), 64'(0));
        check("rst_s1_ready", 64'(s1_ready), 64'(0));
        check("rst_sh_valid_in", 64'(sh_valid_in), 64'(0));
        check("rst_sh_enable", 64'(sh_enable), 64'(1));
        check("rst_count", 64'(dut.fifo_count), 64'(0));
        drive(0, 1'b0, 8'h00, 0, 1'b0);
        drive(1, 1'b0, 8'h00, 0, 1'b0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;

        // Single 3-beat packet on s0, first-beat latency.
        mon_q.delete();
        send_pkt(0, 3, 8'hA0, 99);
        wait_beats(3, "single");
        if (mon_q.size() > 0) check("single_latency", 64'(mon_q[0].c - hs_cyc), 64'(LAT + 1));
        for (int b = 0; b < 3; b++) check_beat(b, 8'hA0, b, b == 2, 1'b0);

        // One-beat s1 packet hands the round-robin pointer back to s0.
        mon_q.delete();
        send_pkt(1, 1, 8'hC0, 99);
        wait_beats(1, "rr_align");
        check_beat(0, 8'hC0, 0, 1'b1, 1'b1);

        // Fairness: both requesters busy with 2-beat packets.
        mon_q.delete();
        fork
            send_pkts(0, 2, 2, 8'h10);
            send_pkts(1, 2, 2, 8'h20);
        join
        wait_beats(8, "fair");
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2; b++)
                check_beat(p * 2 + b, (p % 2 == 0) ? 8'h10 + 8'(p / 2) : 8'h20 + 8'(p / 2),
                           b, b == 1, 1'(p % 2));

        // Backpressure: m_ready low for 20 cycles during a 10-beat s1 packet.
        mon_q.delete();
        m_ready = 1'b0;
        fork
            send_pkt(1, 10, 8'h30, 99);
            begin
                repeat (18) @(negedge aclk);
                check("bp_count_full", 64'(dut.fifo_count), 64'(4));
                check("bp_sh_enable", 64'(sh_enable), 64'(0));
                check("bp_s1_ready", 64'(s1_ready), 64'(0));
                check("bp_m_valid", 64'(m_valid), 64'(1));
                repeat (2) @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        wait_beats(10, "bp");
        for (int b = 0; b < 10; b++) check_beat(b, 8'h30, b, b == 9, 1'b1);

        // Simultaneous push and pop with two entries held.
        mon_q.delete();
        m_ready = 1'b0;
        fork
            send_pkt(0, 4, 8'h40, 99);
            begin
                wait_count(2);
                check("pp_pre_count", 64'(dut.fifo_count), 64'(2));
                check("pp_pre_valid_out", 64'(sh_valid_out), 64'(1));
                m_ready = 1'b1;
                @(negedge aclk);
                check("pp_count_held", 64'(dut.fifo_count), 64'(2));
                check("pp_sh_enable", 64'(sh_enable), 64'(1));
            end
        join
        wait_beats(4, "pp");
        for (int b = 0; b < 4; b++) check_beat(b, 8'h40, b, b == 3, 1'b0);

        // Reset mid-packet with the FIFO holding data.
        mon_q.delete();
        m_ready = 1'b0;
        send_pkt(1, 2, 8'h5A, 99);
        wait_count(2);
        check("mr_pre_count", 64'(dut.fifo_count), 64'(2));
        @(posedge aclk); #1;
        send_pkt(0, 5, 8'h50, 2);
        areset = 1'b1;
        #1;
        check("mr_m_valid", 64'(m_valid), 64'(0));
        check("mr_s0_ready", 64'(s0_ready), 64'(0));
        check("mr_s1_ready", 64'(s1_ready), 64'(0));
        check("mr_count", 64'(dut.fifo_count), 64'(0));
        check("mr_sh_enable", 64'(sh_enable), 64'(1));
        @(posedge aclk); #1;
        areset = 1'b0;
        m_ready = 1'b1;
        mon_q.delete();
        send_pkt(1, 2, 8'h60, 99);
        check("mr_grant_s1", 64'(dut.grant), 64'(1));
        wait_beats(2, "mr");
        for (int b = 0; b < 2; b++) check_beat(b, 8'h60, b, b == 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
